// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
package fifo_burst_reader_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_LEN_W     = 5;
    localparam int unsigned DEF_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/fifo_burst_reader_buf.sv
// Small circular output buffer: push from the FIFO read path, pop on stream handshake.
// The caller guarantees a push never lands on a full buffer after the same-cycle pop.
module fifo_burst_reader_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_BUF_DEPTH,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_do_pop;

    assign w_do_pop = i_pop && o_valid;
    assign o_valid  = (r_count != '0);
    // Drive zero when empty so the output is clean out of reset.
    assign o_data   = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count  = r_count;

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        unique case ({i_push, w_do_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointer and count registers, pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Storage array; contents are meaningless whenever the count says empty.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops a requested number of words from a synchronous FIFO and
// streams them out on valid/ready without losing data under backpressure.
// Optional statistics counters are enabled with `define FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_fifo_empty,
    input  logic              i_fifo_wr,
    output logic              o_fifo_rd,
    input  logic [DATA_W-1:0] i_fifo_dout,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    input  logic              i_m_ready
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]       o_word_cnt,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_next;
    logic             r_inflight;
    logic [CNT_W-1:0] w_buf_count;
    logic             w_pop;
    logic [OCC_W-1:0] w_occupancy;
    logic             w_room;

    assign w_pop = o_m_valid && i_m_ready;

    // Slots committed after this cycle: buffered + word arriving from the FIFO - word leaving.
    assign w_occupancy = OCC_W'(w_buf_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_room      = (w_occupancy < OCC_W'(BUF_DEPTH));

    // FIFO ignores rd while wr is high, so never issue one then.
    assign o_fifo_rd = (r_state == StRun) && (r_remaining != '0) && !i_fifo_empty &&
                       !i_fifo_wr && w_room;

    assign o_busy = (r_state == StRun) || (r_state == StFlush);
    assign o_done = (r_state == StDone);

    // Next-state and burst length bookkeeping.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_state_next     = StRun;
                        w_remaining_next = i_len;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StRun: begin
                if (o_fifo_rd) begin
                    w_remaining_next = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!r_inflight && (w_buf_count == '0)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, remaining count and read-in-flight flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_inflight  <= o_fifo_rd;
        end
    end

    fifo_burst_reader_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_dout),
        .i_pop       (w_pop),
        .o_valid     (o_m_valid),
        .o_data      (o_m_data),
        .o_count     (w_buf_count)
    );

`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0] r_word_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating handshake and empty-stall counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && (r_word_cnt != 16'hFFFF)) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            if ((r_state == StRun) && i_fifo_empty && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_word_cnt  = r_word_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO model plus an in-order word scoreboard.
module tb_fifo_burst_reader;
    import fifo_burst_reader_pkg::*;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 5;
    localparam int unsigned BUF_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0]       word_cnt;
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .i_fifo_empty (fifo_empty),
        .i_fifo_wr    (fifo_wr),
        .o_fifo_rd    (fifo_rd),
        .i_fifo_dout  (fifo_dout),
        .o_m_valid    (m_valid),
        .o_m_data     (m_data),
        .i_m_ready    (m_ready)
`ifdef FIFO_BURST_READER_STATS_EN
        ,
        .o_word_cnt   (word_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    // FIFO contents and every word that must still appear on the stream, in order.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] wdata;

    int checks = 0;
    int errors = 0;

    int cyc, delivered, done_cnt, rd_cnt, valid_cnt, stall_rds, total_hs;
    int first_valid, first_hs, last_hs, first_rd, last_rd, done_cyc;
    int ro_start, ro_end, wr_start, wr_count;
    bit done_seen, in_burst, prev_stall, rand_ready;
    logic [DATA_W-1:0] prev_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic preload(input int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DATA_W'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock: drive inputs, check at the falling edge, then advance the FIFO model.
    task automatic cycle();
        bit rd_s;
        bit wr_s;
        if (cyc >= ro_start && cyc < ro_end) m_ready = 1'b0;
        else m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc >= wr_start && cyc < wr_start + wr_count) begin
            fifo_wr = 1'b1;
            wdata   = DATA_W'($urandom);
        end else begin
            fifo_wr = 1'b0;
        end
        @(negedge clk);
        if (fifo_rd) begin
            check_bit("rd_while_empty", fifo_empty, 1'b0);
            check_bit("rd_while_wr", fifo_wr, 1'b0);
            rd_cnt++;
            if (cyc < ro_end) stall_rds++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (prev_stall) begin
            check_bit("hold_valid", m_valid, 1'b1);
            check_val("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (m_valid && m_ready) begin
            check_bit("word_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check_val("data", 32'(m_data), 32'(exp_q.pop_front()));
            delivered++;
            total_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        if (in_burst && cyc >= 1 && !done_seen && !done) check_bit("busy", busy, 1'b1);
        if (done) begin
            done_cnt++;
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        rd_s = fifo_rd;
        wr_s = fifo_wr;
        @(posedge clk);
        #1;
        if (wr_s) begin
            fifo_q.push_back(wdata);
            exp_q.push_back(wdata);
        end else if (rd_s && fifo_q.size() != 0) begin
            fifo_dout = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic start_burst(input int n);
        cyc = 0; delivered = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; stall_rds = 0;
        first_valid = -1; first_hs = -1; last_hs = -1; first_rd = -1; last_rd = -1;
        done_cyc = -1; done_seen = 1'b0; in_burst = 1'b1;
        start = 1'b1;
        len   = LEN_W'(n);
        cycle();
        start = 1'b0;
    endtask

    task automatic run_burst(input int n, input int budget);
        start_burst(n);
        while (!done_seen && cyc < budget) cycle();
        in_burst = 1'b0;
        check_bit("done_seen", done_seen, 1'b1);
        check_val("delivered", delivered, n);
        cycle();
        check_val("done_pulses", done_cnt, 1);
        check_bit("idle_busy", busy, 1'b0);
    endtask

    task automatic clear_cfg();
        ro_start = 0; ro_end = 0; wr_start = 0; wr_count = 0; rand_ready = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        rst_n = 1'b0; start = 1'b0; len = '0; fifo_wr = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0; wdata = '0;
        prev_stall = 1'b0; prev_data = '0; total_hs = 0; in_burst = 1'b0;
        done_seen = 1'b0; cyc = 0;
        clear_cfg();

        // Reset state.
        #1;
        check_bit("rst_rd", fifo_rd, 1'b0);
        check_bit("rst_valid", m_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_val("rst_data", 32'(m_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst of four fixed words.
        fifo_q.push_back(8'hA1); exp_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2); exp_q.push_back(8'hA2);
        fifo_q.push_back(8'hA3); exp_q.push_back(8'hA3);
        fifo_q.push_back(8'hA4); exp_q.push_back(8'hA4);
        fifo_empty = 1'b0;
        run_burst(4, 100);
        check_val("basic_rd_count", rd_cnt, 4);
        check_val("basic_rd_span", last_rd - first_rd + 1, 4);
        check_val("basic_first_valid", first_valid, 3);
        check_val("basic_hs_span", last_hs - first_hs + 1, 4);
        check_bit("basic_done_after_last", done_cyc > last_hs, 1'b1);

        // Reset mid-burst with words parked in the output buffer.
        preload(10);
        ro_start = 0; ro_end = 1000;
        start_burst(10);
        repeat (4) cycle();
        check_bit("pre_reset_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        total_hs = 0;
        #1;
        check_bit("async_rd", fifo_rd, 1'b0);
        check_bit("async_valid", m_valid, 1'b0);
        check_bit("async_busy", busy, 1'b0);
        check_bit("async_done", done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_burst = 1'b0;
        exp_q = fifo_q;
        prev_stall = 1'b0;
        clear_cfg();
        @(posedge clk);
        #1;
        check_bit("post_reset_busy", busy, 1'b0);
        check_bit("post_reset_done", done, 1'b0);
        run_burst(fifo_q.size(), 200);

        // Backpressure: output stalled while the buffer fills.
        preload(10);
        ro_start = 3; ro_end = 9;
        run_burst(10, 200);
        check_bit("stall_rds_le_depth", stall_rds <= BUF_DEPTH, 1'b1);
        clear_cfg();

        // Underflow: FIFO runs dry mid-burst, refilled later.
        preload(3);
        wr_start = 10; wr_count = 5;
        run_burst(8, 200);
        clear_cfg();

        // Writer contention during RUN.
        preload(7);
        wr_start = 3; wr_count = 3;
        run_burst(10, 200);
        clear_cfg();

        // Zero-length request.
        run_burst(0, 20);
        check_val("zero_done_cyc", done_cyc, 1);
        check_val("zero_rd", rd_cnt, 0);
        check_val("zero_valid", valid_cnt, 0);

        // Randomised bursts with random backpressure and late refills.
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 16));
            p = int'($urandom_range(0, n));
            preload(p);
            wr_start = int'($urandom_range(2, 8));
            wr_count = n - p;
            rand_ready = 1'b1;
            run_burst(n, 300);
            clear_cfg();
        end
        check_val("fifo_drained", fifo_q.size(), 0);
        check_val("stream_drained", exp_q.size(), 0);

`ifdef FIFO_BURST_READER_STATS_EN
        check_val("word_cnt", 32'(word_cnt), total_hs);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
